// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD add/sub datapath:
// digit width, BCD limits, controller states and the 9's-complement helper.
package bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] BCD_CORR    = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // 9's complement of one BCD digit (meaningful for digits 0..9 only)
  function automatic logic [3:0] nines_comp(input logic [3:0] digit);
    return BCD_MAX - digit;
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// One-digit BCD adder: digit + digit + carry-in, decimal-corrected.
// Shared by the add/sub pass and the 10's-complement fix-up pass.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] raw_s;

  // binary add, then +6 correction when the digit exceeds 9
  always_comb begin
    raw_s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (raw_s > {1'b0, BCD_MAX}) begin
      sum  = raw_s[3:0] + BCD_CORR;
      cout = 1'b1;
    end else begin
      sum  = raw_s[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one decimal digit per clock.
// Subtraction adds the 9's complement of B plus one; a negative result is
// turned into its magnitude by a second serial 10's-complement pass (FIX).
// Optional build macro: BCD_DIGIT_CHECK_EN (flags operand digits > 9 as err).
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  neg,
  output logic                  err
);

  localparam int W     = BCD_DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic [W-1:0]     res_r;
  logic [W-1:0]     b_opnd_s;
  logic [W-1:0]     res_shift_s;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic             sub_r;
  logic             cout_r;
  logic             neg_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             accept_s;
  logic             last_s;
  logic             bad_s;
  logic [3:0]       add_a_s;
  logic [3:0]       add_b_s;
  logic             add_cin_s;
  logic [3:0]       add_sum_s;
  logic             add_co_s;

  assign accept_s = in_valid & in_ready_r;
  assign last_s   = (idx_r == LAST_IDX);

`ifdef BCD_DIGIT_CHECK_EN
  logic err_r;

  // any operand digit above 9 marks the request as invalid
  always_comb begin
    bad_s = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if ((a[d*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX) ||
          (b[d*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX)) begin
        bad_s = 1'b1;
      end else begin
        bad_s = bad_s;
      end
    end
  end

  // error flag: set on a rejected accept, cleared by the next good accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (accept_s) begin
      err_r <= bad_s;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  assign bad_s = 1'b0;
  assign err   = 1'b0;
`endif

  // B operand as latched: straight for add, digit-wise 9's complement for sub
  always_comb begin
    b_opnd_s = {W{1'b0}};
    for (int d = 0; d < DIGITS; d++) begin
      if (sub) begin
        b_opnd_s[d*BCD_DIGIT_W +: BCD_DIGIT_W] = nines_comp(b[d*BCD_DIGIT_W +: BCD_DIGIT_W]);
      end else begin
        b_opnd_s[d*BCD_DIGIT_W +: BCD_DIGIT_W] = b[d*BCD_DIGIT_W +: BCD_DIGIT_W];
      end
    end
  end

  // digit adder operands: operand LSDs in RUN, complemented result LSD in FIX
  always_comb begin
    add_a_s   = 4'd0;
    add_b_s   = 4'd0;
    add_cin_s = 1'b0;
    case (state_r)
      RUN: begin
        add_a_s   = a_r[BCD_DIGIT_W-1:0];
        add_b_s   = b_r[BCD_DIGIT_W-1:0];
        add_cin_s = carry_r;
      end
      FIX: begin
        add_a_s   = nines_comp(res_r[BCD_DIGIT_W-1:0]);
        add_b_s   = 4'd0;
        add_cin_s = carry_r;
      end
      default: begin
        add_a_s   = 4'd0;
        add_b_s   = 4'd0;
        add_cin_s = 1'b0;
      end
    endcase
  end

  bcd_digit_adder u_digit (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .sum  (add_sum_s),
    .cout (add_co_s)
  );

  // result shifts right one digit per step; the new digit enters at the top,
  // so after DIGITS steps digit 0 sits back at bits [3:0]
  always_comb begin
    res_shift_s = res_r >> BCD_DIGIT_W;
    res_shift_s[W-1 -: BCD_DIGIT_W] = add_sum_s;
  end

  // controller next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (bad_s) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = RUN;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          if (sub_r && !add_co_s) begin
            state_nxt_s = FIX;
          end else begin
            state_nxt_s = DONE;
          end
        end else begin
          state_nxt_s = RUN;
        end
      end
      FIX: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = FIX;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // state register with handshake flags decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  // operand shifters, digit index, carry chain and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      res_r   <= {W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      carry_r <= 1'b0;
      sub_r   <= 1'b0;
      cout_r  <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r     <= a;
            b_r     <= b_opnd_s;
            idx_r   <= {IDX_W{1'b0}};
            carry_r <= sub;
            sub_r   <= sub;
            cout_r  <= 1'b0;
            neg_r   <= 1'b0;
            if (bad_s) begin
              res_r <= {W{1'b0}};
            end else begin
              res_r <= res_r;
            end
          end else begin
            a_r <= a_r;
          end
        end
        RUN: begin
          a_r   <= a_r >> BCD_DIGIT_W;
          b_r   <= b_r >> BCD_DIGIT_W;
          res_r <= res_shift_s;
          if (last_s) begin
            idx_r   <= {IDX_W{1'b0}};
            carry_r <= 1'b1;
            cout_r  <= sub_r ? 1'b0 : add_co_s;
            neg_r   <= sub_r & ~add_co_s;
          end else begin
            idx_r   <= idx_r + IDX_W'(1);
            carry_r <= add_co_s;
          end
        end
        FIX: begin
          res_r <= res_shift_s;
          if (last_s) begin
            idx_r   <= {IDX_W{1'b0}};
            carry_r <= 1'b0;
          end else begin
            idx_r   <= idx_r + IDX_W'(1);
            carry_r <= add_co_s;
          end
        end
        default: begin
          res_r <= res_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = res_r;
  assign cout      = cout_r;
  assign neg       = neg_r;

endmodule
